if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC and issues req/ack fetches to instruction memory.

---
 rtl/if_fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and buffers one instruction for IF/ID.
// Optional feature macro: IF_PERF_CNT_EN adds hold/wait performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_hold_IF,
    input  logic              branch_taken_ID,
    input  logic [31:0]       branch_target_ID,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid_IF,
    output logic [31:0]       pc_IF,
    output logic [INST_W-1:0] inst_IF
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       hold_cycles_IF,
    output logic [31:0]       wait_cycles_IF
`endif
);

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic                drop_q, drop_d;
    logic                valid_q, valid_d;
    logic [31:0]         pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                consume_s;
    logic                can_issue_s;

    assign consume_s     = valid_q & ~is_hold_IF;
    assign can_issue_s   = ~valid_q | ~is_hold_IF;
    assign inst_valid_IF = valid_q;
    assign pc_IF         = pc_q;
    assign inst_IF       = inst_q;

    // State register for the fetch FSM, PC and output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_READY;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= 32'h0000_0000;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= 32'h0000_0000;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    // Next-state and memory-request logic; a redirect outranks every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        imem_req   = 1'b0;
        imem_addr  = fetch_pc_q;
        if (consume_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_READY: begin
                imem_req  = can_issue_s & ~branch_taken_ID & ~rst;
                imem_addr = fetch_pc_q;
                if (branch_taken_ID) begin
                    fetch_pc_d = branch_target_ID;
                    valid_d    = 1'b0;
                end else if (imem_req && imem_ack) begin
                    valid_d    = 1'b1;
                    pc_d       = fetch_pc_q;
                    inst_d     = imem_rdata;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (imem_req) begin
                    state_d    = ST_WAIT;
                    req_addr_d = fetch_pc_q;
                end else begin
                    state_d    = ST_READY;
                end
            end
            ST_WAIT: begin
                // The outstanding address is held in req_addr_q so a redirect cannot disturb it.
                imem_req  = ~rst;
                imem_addr = req_addr_q;
                if (branch_taken_ID) begin
                    fetch_pc_d = branch_target_ID;
                    valid_d    = 1'b0;
                    if (imem_ack) begin
                        state_d = ST_READY;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_ack) begin
                    state_d = ST_READY;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        valid_d    = 1'b1;
                        pc_d       = req_addr_q;
                        inst_d     = imem_rdata;
                        fetch_pc_d = req_addr_q + 32'd4;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    assign hold_cycles_IF = hold_cnt_q;
    assign wait_cycles_IF = wait_cnt_q;

    // Saturating increments for the stall counters.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (valid_q && is_hold_IF && (hold_cnt_q != 32'hFFFF_FFFF)) begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
        if (imem_req && !imem_ack && (wait_cnt_q != 32'hFFFF_FFFF)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 32'h0000_0000;
            wait_cnt_q <= 32'h0000_0000;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized traffic vs. a transaction model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_hold_IF;
    logic        branch_taken_ID;
    logic [31:0] branch_target_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid_IF;
    logic [31:0] pc_IF;
    logic [31:0] inst_IF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] hold_cycles_IF;
    logic [31:0] wait_cycles_IF;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: next PC to fetch, the outstanding request, and the presented instruction.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        m_drop;
    logic        m_valid;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;
    logic [31:0] m_hold_cnt;
    logic [31:0] m_wait_cnt;

    if_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .is_hold_IF       (is_hold_IF),
        .branch_taken_ID  (branch_taken_ID),
        .branch_target_ID (branch_target_ID),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .inst_valid_IF    (inst_valid_IF),
        .pc_IF            (pc_IF),
        .inst_IF          (inst_IF)
`ifdef IF_PERF_CNT_EN
        ,
        .hold_cycles_IF   (hold_cycles_IF),
        .wait_cycles_IF   (wait_cycles_IF)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_paddr = 32'h0; m_drop = 1'b0;
        m_valid = 1'b0; m_bpc = 32'h0; m_binst = 32'h0;
        m_hold_cnt = 32'h0; m_wait_cnt = 32'h0;
    endtask

    // One clock: drive inputs, check the request, advance the model, check the presented instruction.
    task automatic cycle(input logic r, input logic hold, input logic br,
                         input logic [31:0] tgt, input logic want_ack);
        logic        e_req;
        logic [31:0] e_addr;
        logic        ack;
        @(negedge clk);
        rst = r; is_hold_IF = hold; branch_taken_ID = br; branch_target_ID = tgt;
        if (r) begin
            e_req = 1'b0;
        end else if (m_pend) begin
            e_req = 1'b1;
        end else begin
            e_req = (!m_valid || !hold) && !br;
        end
        e_addr = m_pend ? m_paddr : m_pc;
        ack = want_ack && e_req;
        imem_ack = ack;
        imem_rdata = mem_word(e_addr);
        #1;
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);

        if (r) begin
            model_reset();
        end else begin
            if (m_valid && hold && m_hold_cnt != 32'hFFFF_FFFF) m_hold_cnt++;
            if (e_req && !ack && m_wait_cnt != 32'hFFFF_FFFF) m_wait_cnt++;
            if (m_valid && !hold) m_valid = 1'b0;
            if (br) begin
                m_pc = tgt;
                m_valid = 1'b0;
                if (m_pend) begin
                    if (ack) begin m_pend = 1'b0; m_drop = 1'b0; end
                    else m_drop = 1'b1;
                end
            end else if (e_req) begin
                if (ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        m_valid = 1'b1; m_bpc = e_addr; m_binst = mem_word(e_addr);
                        m_pc = e_addr + 32'd4;
                    end
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1; m_paddr = e_addr;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("inst_valid_IF", {31'd0, inst_valid_IF}, {31'd0, m_valid});
        if (m_valid || r) begin
            chk("pc_IF", pc_IF, m_bpc);
            chk("inst_IF", inst_IF, m_binst);
        end
`ifdef IF_PERF_CNT_EN
        chk("hold_cycles_IF", hold_cycles_IF, m_hold_cnt);
        chk("wait_cycles_IF", wait_cycles_IF, m_wait_cnt);
`endif
    endtask

    initial begin
        rst = 1'b1; is_hold_IF = 1'b0; branch_taken_ID = 1'b0;
        branch_target_ID = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // 1. reset for two cycles, with a redirect that must be ignored
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        chk("reset_valid", {31'd0, inst_valid_IF}, 32'd0);

        // 2. zero-wait memory: pc 0,4,8 back to back
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("first_pc", pc_IF, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("second_pc", pc_IF, 32'h0000_0004);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("third_pc", pc_IF, 32'h0000_0008);

        // 3. hold three cycles at pc 8, then release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("held_pc", pc_IF, 32'h0000_0008);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("after_hold_pc", pc_IF, 32'h0000_000C);

        // 4. slow memory, ack three cycles late while hold toggles
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("slow_pc", pc_IF, 32'h0000_0010);

        // 5. redirect while waiting: late data discarded, next fetch at 0x100
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("drop_valid", {31'd0, inst_valid_IF}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redirect_pc", pc_IF, 32'h0000_0100);

        // 6. redirect to 0x40 while valid and held
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        chk("flush_valid", {31'd0, inst_valid_IF}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush_pc", pc_IF, 32'h0000_0040);

        // address wrap at the top of memory
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", pc_IF, 32'h0000_0000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
